pipeline_sequencer: RTL

Central stall/flush controller for the 5-stage PSRV32 pipeline (IF, ID, EX, MEM, WB).
- Consumes hazard information from the ID stage, the EX stage, and the data-memory handshake.
- Drives per-stage register enables and flushes so that decoded control (alu_op, mem_read, reg_write, jump, branch) advances, freezes or is squashed coherently.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pipeline_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage PSRV32 pipeline: resolves memory stalls,
// EX redirects and load-use hazards into per-stage enables/flushes, plus perf counters.
module pipeline_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  localparam int unsigned FC_W   = 3;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [FC_W-1:0]   r_fcnt;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_mem_err;

  logic [1:0]        w_next_state;
  logic [FC_W-1:0]   w_next_fcnt;
  logic              w_flush_event;
  logic              w_mem_stall;
  logic              w_in_redirect;
  logic              w_load_use;

  assign w_mem_stall = mem_req_i & ~mem_ready_i;

  // A MEM_WAIT with a held, non-zero flush count was entered from REDIRECT.
  assign w_in_redirect = (r_state == S_REDIRECT) ||
                         ((r_state == S_MEM_WAIT) && (r_fcnt != '0));

  assign w_load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  // Priority decision: reset > memory stall > redirect (active or new) > load-use.
  always_comb begin
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_en_o      = 1'b1;
    idex_flush_o   = 1'b0;
    exmem_en_o     = 1'b1;
    memwb_bubble_o = 1'b0;
    w_next_state   = S_RUN;
    w_next_fcnt    = r_fcnt;
    w_flush_event  = 1'b0;

    if (!rst_ni) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_en_o      = 1'b0;
      idex_flush_o   = 1'b1;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (w_mem_stall) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
      w_next_state   = S_MEM_WAIT;
    end else if (w_in_redirect) begin
      // EX already squashed: a new ex_redirect_i here is ignored.
      ifid_flush_o = 1'b1;
      w_next_fcnt  = r_fcnt - FC_W'(1);
      w_next_state = (r_fcnt == FC_W'(1)) ? S_RUN : S_REDIRECT;
    end else if (ex_redirect_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      w_flush_event = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_next_state = S_REDIRECT;
        w_next_fcnt  = FC_W'(FLUSH_CYCLES - 1);
      end
    end else if (w_load_use) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_RUN;
      r_fcnt      <= '0;
      r_wait      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_fcnt  <= w_next_fcnt;

      if (!pc_en_o && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_event && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end

      // Timeout only flags the error; the stall itself is never broken.
      if (w_mem_stall) begin
        if (r_wait != WAIT_MAX) begin
          r_wait <= r_wait + WAIT_W'(1);
        end
        if (r_wait >= WAIT_LAST) begin
          r_mem_err <= 1'b1;
        end
      end else begin
        r_wait <= '0;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
  assign mem_err_o   = r_mem_err;

endmodule
